// File: rtl/vram_pkg.sv
// vram_pkg: shared frame-buffer geometry constants and owner tags
package vram_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 12;
  localparam int FB_WORDS = 307200;
  typedef enum logic [1:0] {TAG_NONE, TAG_SCAN, TAG_SCAN_BLANK, TAG_CPU} owner_tag_t;
endpackage

// File: rtl/vram_addr_calc.sv
// vram_addr_calc: row/col to frame-buffer word address via shift-add, with visibility flag
module vram_addr_calc
  import vram_pkg::*;
(
  input  logic [8:0]        row,
  input  logic [9:0]        col,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range
);
  always_comb begin
    addr = (ADDR_W'(row) << 9) + (ADDR_W'(row) << 7) + ADDR_W'(col);
    in_range = (row < 9'(V_ACTIVE)) && (col < 10'(H_ACTIVE));
  end
endmodule

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: shares the frame-buffer RAM port between VGA scanout and the CPU bus
module vram_port_arbiter
  import vram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_ce,
  input  logic [8:0]        row_addr,
  input  logic [9:0]        col_addr,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);
  logic [ADDR_W-1:0] scan_addr;
  logic scan_ok, grant_cpu, cpu_ok, cpu_busy, zero1, zero2;
  owner_tag_t tag, tag1, tag2;
  vram_addr_calc u_calc (
    .row(row_addr),
    .col(col_addr),
    .addr(scan_addr),
    .in_range(scan_ok)
  );
  always_comb begin
    grant_cpu = !pix_ce && cpu_req && !cpu_busy;
    cpu_ok = cpu_addr < ADDR_W'(FB_WORDS);
    tag = pix_ce ? (scan_ok ? TAG_SCAN : TAG_SCAN_BLANK) : (grant_cpu && !cpu_we) ? TAG_CPU : TAG_NONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr <= '0;
      ram_we <= 1'b0;
      ram_din <= '0;
      tag1 <= TAG_NONE;
      tag2 <= TAG_NONE;
      zero1 <= 1'b0;
      zero2 <= 1'b0;
      cpu_busy <= 1'b0;
      cpu_ack <= 1'b0;
      cpu_rdata <= '0;
      pix_valid <= 1'b0;
      pix_data <= '0;
    end else begin
      ram_addr <= (pix_ce && scan_ok) ? scan_addr : grant_cpu ? cpu_addr : ram_addr;
      ram_we <= grant_cpu && cpu_we && cpu_ok;
      ram_din <= grant_cpu ? cpu_wdata : ram_din;
      tag1 <= tag;
      tag2 <= tag1;
      zero1 <= !cpu_ok;
      zero2 <= zero1;
      cpu_busy <= grant_cpu || (cpu_busy && !cpu_ack);
      cpu_ack <= (grant_cpu && cpu_we) || (tag2 == TAG_CPU);
      cpu_rdata <= (tag2 == TAG_CPU) ? (zero2 ? '0 : ram_dout) : cpu_rdata;
      pix_valid <= (tag2 == TAG_SCAN) || (tag2 == TAG_SCAN_BLANK);
      pix_data <= (tag2 == TAG_SCAN) ? ram_dout : (tag2 == TAG_SCAN_BLANK) ? '0 : pix_data;
    end
  end
endmodule

// File: tb/tb_vram_port_arbiter.sv
// tb_vram_port_arbiter: directed and randomized self-checking bench with a RAM model
module tb_vram_port_arbiter;
  localparam int FB = 307200;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_ce = 1'b0;
  logic [8:0] row_addr = '0;
  logic [9:0] col_addr = '0;
  logic [11:0] pix_data;
  logic pix_valid;
  logic cpu_req = 1'b0;
  logic cpu_we = 1'b0;
  logic [18:0] cpu_addr = '0;
  logic [11:0] cpu_wdata = '0;
  logic [11:0] cpu_rdata;
  logic cpu_ack;
  logic [18:0] ram_addr;
  logic ram_we;
  logic [11:0] ram_din;
  logic [11:0] ram_dout = '0;
  logic [11:0] mem [FB];
  logic poke_en = 1'b0;
  logic [18:0] poke_addr = '0;
  logic [11:0] poke_data = '0;
  logic [11:0] ref_mem [64];
  logic cpu_done = 1'b0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [8:0]  row;
    logic [9:0]  col;
    logic [18:0] addr;
    logic [11:0] data;
    logic        blank;
  } vec_t;
  vec_t vt [8];

  vram_port_arbiter dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .row_addr(row_addr), .col_addr(col_addr),
    .pix_data(pix_data), .pix_valid(pix_valid), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (ram_we && ram_addr < 19'(FB)) mem[ram_addr] <= ram_din;
    ram_dout <= (ram_addr < 19'(FB)) ? mem[ram_addr] : 12'hBAD;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [18:0] a, input logic [11:0] d);
    poke_en = 1'b1;
    poke_addr = a;
    poke_data = d;
    tick();
    poke_en = 1'b0;
  endtask

  task automatic cpu_op(input logic we, input logic [18:0] a, input logic [11:0] d,
                        output logic [11:0] rd, output int lat);
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = a;
    cpu_wdata = d;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!cpu_ack && lat < 20);
    rd = cpu_rdata;
    cpu_req = 1'b0;
  endtask

  initial begin
    logic [11:0] rd;
    int lat;
    int acks;
    int bad;
    vt[0] = '{9'd1,   10'd2,    19'd642,    12'h5A3, 1'b0};
    vt[1] = '{9'd0,   10'd0,    19'd0,      12'h001, 1'b0};
    vt[2] = '{9'd479, 10'd639,  19'd307199, 12'hFED, 1'b0};
    vt[3] = '{9'd2,   10'd0,    19'd1280,   12'h123, 1'b0};
    vt[4] = '{9'd100, 10'd37,   19'd64037,  12'h7C4, 1'b0};
    vt[5] = '{9'd480, 10'd0,    19'd0,      12'h000, 1'b1};
    vt[6] = '{9'd0,   10'd640,  19'd0,      12'h000, 1'b1};
    vt[7] = '{9'd511, 10'd1023, 19'd0,      12'h000, 1'b1};
    for (int i = 0; i < 8; i++) if (!vt[i].blank) poke(vt[i].addr, vt[i].data);
    poke(19'd10, 12'h0A5);
    poke(19'd1285, 12'h3C3);
    poke(19'd640, 12'h9E1);
    tick();
    chk("rst_pix_data", 32'(pix_data), 0);
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
    chk("rst_cpu_ack", 32'(cpu_ack), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_din", 32'(ram_din), 0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      row_addr = vt[i].row;
      col_addr = vt[i].col;
      pix_ce = 1'b1;
      tick();
      pix_ce = 1'b0;
      chk("scan_we", 32'(ram_we), 0);
      if (!vt[i].blank) chk("scan_addr", 32'(ram_addr), 32'(vt[i].addr));
      chk("scan_valid_n1", 32'(pix_valid), 0);
      tick();
      chk("scan_valid_n2", 32'(pix_valid), 0);
      tick();
      chk("scan_valid_n3", 32'(pix_valid), 1);
      chk("scan_data", 32'(pix_data), 32'(vt[i].data));
      tick();
      chk("scan_valid_n4", 32'(pix_valid), 0);
    end
    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_addr = 19'd256;
    cpu_wdata = 12'hABC;
    tick();
    cpu_req = 1'b0;
    chk("wr_ram_we", 32'(ram_we), 1);
    chk("wr_ram_addr", 32'(ram_addr), 256);
    chk("wr_ram_din", 32'(ram_din), 32'h0ABC);
    chk("wr_ack", 32'(cpu_ack), 1);
    tick();
    chk("wr_ack_pulse", 32'(cpu_ack), 0);
    chk("wr_ram_we_off", 32'(ram_we), 0);
    cpu_op(1'b0, 19'd256, 12'h000, rd, lat);
    chk("rd_lat", 32'(lat), 3);
    chk("rd_data", 32'(rd), 32'h0ABC);
    tick();
    row_addr = 9'd2;
    col_addr = 10'd5;
    pix_ce = 1'b1;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 19'd10;
    tick();
    pix_ce = 1'b0;
    chk("col_addr_n1", 32'(ram_addr), 1285);
    tick();
    chk("col_addr_n2", 32'(ram_addr), 10);
    chk("col_ack_n2", 32'(cpu_ack), 0);
    tick();
    chk("col_valid_n3", 32'(pix_valid), 1);
    chk("col_pix_n3", 32'(pix_data), 32'h3C3);
    chk("col_ack_n3", 32'(cpu_ack), 0);
    tick();
    cpu_req = 1'b0;
    chk("col_ack_n4", 32'(cpu_ack), 1);
    chk("col_rdata_n4", 32'(cpu_rdata), 32'h0A5);
    chk("col_valid_n4", 32'(pix_valid), 0);
    tick();
    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_addr = 19'd307200;
    cpu_wdata = 12'h777;
    tick();
    cpu_req = 1'b0;
    chk("oor_wr_we", 32'(ram_we), 0);
    chk("oor_wr_ack", 32'(cpu_ack), 1);
    tick();
    cpu_op(1'b0, 19'd307200, 12'h000, rd, lat);
    chk("oor_rd_lat", 32'(lat), 3);
    chk("oor_rd_data", 32'(rd), 0);
    tick();
    row_addr = 9'd1;
    col_addr = 10'd0;
    pix_ce = 1'b1;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 19'd256;
    tick();
    pix_ce = 1'b0;
    tick();
    rst = 1'b1;
    cpu_req = 1'b0;
    tick();
    rst = 1'b0;
    chk("rr_pix_data", 32'(pix_data), 0);
    chk("rr_pix_valid", 32'(pix_valid), 0);
    chk("rr_cpu_rdata", 32'(cpu_rdata), 0);
    chk("rr_cpu_ack", 32'(cpu_ack), 0);
    chk("rr_ram_addr", 32'(ram_addr), 0);
    chk("rr_ram_we", 32'(ram_we), 0);
    chk("rr_ram_din", 32'(ram_din), 0);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      acks += int'(cpu_ack) + int'(pix_valid);
      tick();
    end
    chk("rr_no_stale", 32'(acks), 0);
    cpu_op(1'b0, 19'd256, 12'h000, rd, lat);
    chk("rr_after_lat", 32'(lat), 3);
    chk("rr_after_data", 32'(rd), 32'h0ABC);
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = 12'($urandom);
      poke(19'(i), ref_mem[i]);
    end
    tick();
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          logic we;
          logic oor;
          int idx;
          logic [11:0] d;
          logic [11:0] r;
          int l;
          we = 1'($urandom_range(0, 1));
          oor = ($urandom_range(0, 7) == 0);
          idx = int'($urandom_range(0, 63));
          d = 12'($urandom);
          cpu_op(we, oor ? 19'(FB + idx) : 19'(idx), d, r, l);
          chk("rnd_lat", 32'(l >= (we ? 1 : 3) && l <= (we ? 2 : 4)), 1);
          if (we) begin
            if (!oor) ref_mem[idx] = d;
          end else begin
            chk("rnd_rdata", 32'(r), oor ? 32'd0 : 32'(ref_mem[idx]));
          end
        end
        cpu_done = 1'b1;
      end
      begin
        while (!cpu_done) begin
          logic [8:0] r;
          logic [9:0] c;
          logic bl;
          logic [11:0] ed;
          int ea;
          r = 9'($urandom_range(10, 500));
          c = 10'($urandom_range(0, 700));
          bl = (r >= 9'd480) || (c >= 10'd640);
          ea = int'(r) * 640 + int'(c);
          ed = bl ? 12'h000 : mem[ea];
          row_addr = r;
          col_addr = c;
          pix_ce = 1'b1;
          tick();
          pix_ce = 1'b0;
          chk("rnd_scan_we", 32'(ram_we), 0);
          tick();
          chk("rnd_scan_n2", 32'(pix_valid), 0);
          tick();
          chk("rnd_scan_n3", 32'(pix_valid), 1);
          chk("rnd_scan_data", 32'(pix_data), 32'(ed));
          tick();
        end
      end
    join
    tick();
    tick();
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("rnd_mem_image", 32'(bad), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
